// File: rtl/gpu_pkg.sv
`default_nettype none
// ============================================================================
//  Package : gpu_pkg
//  Brief   : Shared types and constants for the per-core control sequencer.
//  Rev     : 1.0  initial release
// ============================================================================
package gpu_pkg;

    localparam int NUM_THREADS_DEFAULT = 4;

    localparam logic [3:0] OP_RET = 4'hF;
    localparam logic [3:0] OP_LDR = 4'h7;
    localparam logic [3:0] OP_STR = 4'h8;

    // IDLE must encode as zero: the debug state port reads 0 out of reset.
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FETCH    = 3'd1,
        ST_DECODE   = 3'd2,
        ST_EXECUTE  = 3'd3,
        ST_WAIT_LSU = 3'd4,
        ST_UPDATE   = 3'd5,
        ST_DONE     = 3'd6
    } state_e;

    // Loads and stores are the only opcodes that wait on the lanes.
    function automatic logic is_mem_op(input logic [3:0] op);
        return (op == OP_LDR) || (op == OP_STR);
    endfunction

endpackage
`default_nettype wire

// File: rtl/core_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Interface : core_scheduler_if
//  Brief     : Dispatcher, program-memory and lane signals of one core.
//              master = scheduler side, slave = environment side.
//              PERF_COUNTER_EN adds the cycle_count signal.
//  Rev       : 1.0  initial release
// ============================================================================
interface core_scheduler_if #(
    parameter int NUM_THREADS    = 4,
    parameter int PROG_ADDR_BITS = 8,
    parameter int INSTR_BITS     = 16
);
    logic                      cu_enable;
    logic                      cu_reset;
    logic [2:0]                cu_active_threads;
    logic                      cu_complete;
    logic                      prog_req_valid;
    logic [PROG_ADDR_BITS-1:0] prog_req_addr;
    logic                      prog_resp_valid;
    logic [INSTR_BITS-1:0]     prog_resp_data;
    logic [INSTR_BITS-1:0]     instr;
    logic [NUM_THREADS-1:0]    thread_mask;
    logic                      exec_en;
    logic [NUM_THREADS-1:0]    lane_busy;
    logic                      branch_taken;
    logic [PROG_ADDR_BITS-1:0] branch_target;
    logic [2:0]                state;
`ifdef PERF_COUNTER_EN
    logic [15:0]               cycle_count;
`endif

    modport master (
`ifdef PERF_COUNTER_EN
        output cycle_count,
`endif
        input  cu_enable, cu_reset, cu_active_threads,
        input  prog_resp_valid, prog_resp_data,
        input  lane_busy, branch_taken, branch_target,
        output cu_complete, prog_req_valid, prog_req_addr,
        output instr, thread_mask, exec_en, state
    );

    modport slave (
`ifdef PERF_COUNTER_EN
        input  cycle_count,
`endif
        output cu_enable, cu_reset, cu_active_threads,
        output prog_resp_valid, prog_resp_data,
        output lane_busy, branch_taken, branch_target,
        input  cu_complete, prog_req_valid, prog_req_addr,
        input  instr, thread_mask, exec_en, state
    );

endinterface
`default_nettype wire

// File: rtl/core_fetcher.sv
`default_nettype none
// ============================================================================
//  Module : core_fetcher
//  Brief  : Program-memory request/response handshake and instruction latch.
//           start opens a request at addr; done flags the accepted response.
//  Rev    : 1.0  initial release
// ============================================================================
module core_fetcher #(
    parameter int PROG_ADDR_BITS = 8,
    parameter int INSTR_BITS     = 16
) (
    input  wire logic                      clk,
    input  wire logic                      rst,
    input  wire logic                      start,
    output logic                           done,
    input  wire logic [PROG_ADDR_BITS-1:0] addr,
    output logic      [INSTR_BITS-1:0]     instr,
    output logic                           prog_req_valid,
    output logic      [PROG_ADDR_BITS-1:0] prog_req_addr,
    input  wire logic                      prog_resp_valid,
    input  wire logic [INSTR_BITS-1:0]     prog_resp_data
);

    logic                  r_req_valid;
    logic [INSTR_BITS-1:0] r_instr;

    // A response only counts while our own request is open, so stale
    // responses after an abandoned fetch fall on the floor.
    assign done           = r_req_valid & prog_resp_valid;
    assign prog_req_valid = r_req_valid;
    assign prog_req_addr  = addr;   // pc is held by the sequencer during FETCH
    assign instr          = r_instr;

    // Request flag opens on start, closes on the accepted response.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_req_valid <= 1'b0;
            r_instr     <= '0;
        end else begin
            if (done) begin
                r_req_valid <= 1'b0;
                r_instr     <= prog_resp_data;
            end else if (start) begin
                r_req_valid <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/core_scheduler.sv
`default_nettype none
// ============================================================================
//  Module : core_scheduler
//  Brief  : Per-core control sequencer. Latches the active lane count on
//           cu_enable, then loops fetch/decode/execute/update until RET,
//           raising cu_complete until the dispatcher resets the core.
//           Optional macro PERF_COUNTER_EN adds a saturating 16-bit count of
//           cycles spent outside IDLE and DONE.
//  Rev    : 1.0  initial release
// ============================================================================
module core_scheduler
    import gpu_pkg::*;
#(
    parameter int NUM_THREADS    = NUM_THREADS_DEFAULT,
    parameter int PROG_ADDR_BITS = 8,
    parameter int INSTR_BITS     = 16
) (
    input  wire logic         clk,
    input  wire logic         reset,
    core_scheduler_if.master  bus
);

    localparam logic [PROG_ADDR_BITS-1:0] c_PC_ONE = {{(PROG_ADDR_BITS-1){1'b0}}, 1'b1};

    state_e                    r_state;
    logic [PROG_ADDR_BITS-1:0] r_pc;
    logic [NUM_THREADS-1:0]    r_mask;
    logic                      r_exec_en;
    logic                      r_complete;

    logic                      w_soft_rst;
    logic                      w_fetch_start;
    logic                      w_fetch_done;
    logic [INSTR_BITS-1:0]     w_instr;
    logic [3:0]                w_opcode;
    logic [NUM_THREADS-1:0]    w_start_mask;

    assign w_soft_rst = reset | bus.cu_reset;
    assign w_opcode   = w_instr[INSTR_BITS-1 -: 4];

    // A fetch opens when a run starts with lanes, and after every UPDATE.
    assign w_fetch_start = ((r_state == ST_IDLE) && bus.cu_enable &&
                            (bus.cu_active_threads != 3'd0)) ||
                           (r_state == ST_UPDATE);

    // Lane i is active iff i < min(count, NUM_THREADS); since i is always
    // below NUM_THREADS the clamp folds into a plain i < count test.
    always_comb begin
        w_start_mask = '0;
        for (int i = 0; i < NUM_THREADS; i++) begin
            w_start_mask[i] = (int'(bus.cu_active_threads) > i);
        end
    end

    core_fetcher #(
        .PROG_ADDR_BITS (PROG_ADDR_BITS),
        .INSTR_BITS     (INSTR_BITS)
    ) u_fetcher (
        .clk             (clk),
        .rst             (w_soft_rst),
        .start           (w_fetch_start),
        .done            (w_fetch_done),
        .addr            (r_pc),
        .instr           (w_instr),
        .prog_req_valid  (bus.prog_req_valid),
        .prog_req_addr   (bus.prog_req_addr),
        .prog_resp_valid (bus.prog_resp_valid),
        .prog_resp_data  (bus.prog_resp_data)
    );

    // Sequencer FSM with registered execute strobe and completion flag.
    always_ff @(posedge clk) begin
        if (w_soft_rst) begin
            r_state    <= ST_IDLE;
            r_pc       <= '0;
            r_mask     <= '0;
            r_exec_en  <= 1'b0;
            r_complete <= 1'b0;
        end else begin
            r_exec_en <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.cu_enable) begin
                        r_pc   <= '0;
                        r_mask <= w_start_mask;
                        if (bus.cu_active_threads == 3'd0) begin
                            r_state    <= ST_DONE;
                            r_complete <= 1'b1;
                        end else begin
                            r_state <= ST_FETCH;
                        end
                    end
                end
                ST_FETCH: begin
                    if (w_fetch_done) r_state <= ST_DECODE;
                end
                ST_DECODE: begin
                    if (w_opcode == OP_RET) begin
                        r_state    <= ST_DONE;
                        r_complete <= 1'b1;
                    end else begin
                        r_state   <= ST_EXECUTE;
                        r_exec_en <= 1'b1;
                    end
                end
                ST_EXECUTE: begin
                    r_state <= is_mem_op(w_opcode) ? ST_WAIT_LSU : ST_UPDATE;
                end
                ST_WAIT_LSU: begin
                    if ((bus.lane_busy & r_mask) == '0) r_state <= ST_UPDATE;
                end
                ST_UPDATE: begin
                    r_pc    <= bus.branch_taken ? bus.branch_target : r_pc + c_PC_ONE;
                    r_state <= ST_FETCH;
                end
                ST_DONE: begin
                    r_state <= ST_DONE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.state       = r_state;
    assign bus.thread_mask = r_mask;
    assign bus.exec_en     = r_exec_en;
    assign bus.cu_complete = r_complete;
    assign bus.instr       = w_instr;

`ifdef PERF_COUNTER_EN
    logic [15:0] r_cycle_count;

    // Count busy cycles, saturating; naturally frozen once in DONE.
    always_ff @(posedge clk) begin
        if (w_soft_rst) begin
            r_cycle_count <= '0;
        end else if ((r_state != ST_IDLE) && (r_state != ST_DONE) &&
                     (r_cycle_count != 16'hFFFF)) begin
            r_cycle_count <= r_cycle_count + 16'd1;
        end
    end

    assign bus.cycle_count = r_cycle_count;
`endif

endmodule
`default_nettype wire
